// File: rtl/kim_fetch_redirect.sv
// kim_fetch_redirect: program counter and IF/ID register for the 5-stage MIPS core.
// Redirects fetch on an ID-stage taken branch, honours hazard stalls, and either
// flushes or keeps the wrong-path (branch+4) instruction.
// Build option: define KIM_BRANCH_DELAY_SLOT_EN for MIPS delay-slot semantics
// (branch+4 is kept in IF/ID). Undefined: branch+4 is replaced by a NOP bubble.
module kim_fetch_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        is_same,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        pc_misalign,
    output logic [15:0] taken_count
);

    typedef enum logic {BOOT, RUN} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{inst: 32'h0, pc4: 32'h0, valid: 1'b0};

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pc_plus4;
    if_id_t      if_id, if_id_nxt;
    logic        misalign, misalign_nxt;
    logic [15:0] cnt, cnt_nxt;

    assign pc_plus4 = pc + 32'd4;

    // Next-state, PC selection and IF/ID load; stall outranks the branch decision.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        if_id_nxt    = if_id;
        misalign_nxt = misalign;
        cnt_nxt      = cnt;
        case (state)
            BOOT: begin
                state_nxt = RUN;
                pc_nxt    = RESET_PC;
                if_id_nxt = BUBBLE;
            end
            RUN: begin
                if (stall) begin
                    // operands not ready: compare result untrusted, hold everything
                end else if (is_same) begin
                    pc_nxt = {branch_target[31:2], 2'b00};
                    if (cnt != 16'hFFFF)
                        cnt_nxt = cnt + 16'd1;
                    if (branch_target[1:0] != 2'b00)
                        misalign_nxt = 1'b1;
`ifdef KIM_BRANCH_DELAY_SLOT_EN
                    if_id_nxt = '{inst: imem_rdata, pc4: pc_plus4, valid: 1'b1};
`else
                    // pc4 still recorded for debug even though the slot is dead
                    if_id_nxt = '{inst: 32'h0, pc4: pc_plus4, valid: 1'b0};
`endif
                end else begin
                    pc_nxt    = pc_plus4;
                    if_id_nxt = '{inst: imem_rdata, pc4: pc_plus4, valid: 1'b1};
                end
            end
            default: begin
                state_nxt = BOOT;
                pc_nxt    = RESET_PC;
                if_id_nxt = BUBBLE;
            end
        endcase
    end

    // State registers; synchronous reset overrides any concurrent branch or stall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            if_id    <= BUBBLE;
            misalign <= 1'b0;
            cnt      <= 16'h0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            if_id    <= if_id_nxt;
            misalign <= misalign_nxt;
            cnt      <= cnt_nxt;
        end
    end

    assign imem_addr   = pc;
    assign if_id_inst  = if_id.inst;
    assign if_id_pc4   = if_id.pc4;
    assign if_id_valid = if_id.valid;
    assign pc_misalign = misalign;
    assign taken_count = cnt;

endmodule

// File: tb/tb_kim_fetch_redirect.sv
// Bench for kim_fetch_redirect: directed test-plan scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model of the fetch rules.
module tb_kim_fetch_redirect;

    localparam logic [31:0] RP = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n, is_same, stall;
    logic [31:0] branch_target, imem_addr, imem_rdata;
    logic [31:0] if_id_inst, if_id_pc4;
    logic        if_id_valid, pc_misalign;
    logic [15:0] taken_count;

    int n_chk = 0;
    int n_fail = 0;

    kim_fetch_redirect #(.RESET_PC(RP)) dut (
        .clk(clk), .reset_n(reset_n), .is_same(is_same),
        .branch_target(branch_target), .stall(stall),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .pc_misalign(pc_misalign),
        .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    // instruction memory contents: a hash of the address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    always_comb imem_rdata = mem(imem_addr);

    // reference model state
    bit          m_boot;
    logic [31:0] m_pc, m_inst, m_pc4;
    bit          m_valid, m_mis;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance the model by one clock using the current inputs
    task automatic model_step();
        if (!reset_n) begin
            m_boot = 1; m_pc = RP; m_inst = 0; m_pc4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
        end else if (m_boot) begin
            m_boot = 0; m_pc = RP; m_inst = 0; m_pc4 = 0; m_valid = 0;
        end else if (stall) begin
            // hold
        end else if (is_same) begin
`ifdef KIM_BRANCH_DELAY_SLOT_EN
            m_inst = mem(m_pc); m_valid = 1;
`else
            m_inst = 0; m_valid = 0;
`endif
            m_pc4 = m_pc + 4;
            m_pc  = branch_target & 32'hFFFF_FFFC;
            if (branch_target % 4 != 0) m_mis = 1;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_inst = mem(m_pc); m_pc4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic compare_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("if_id_inst", if_id_inst, m_inst);
        chk("if_id_pc4", if_id_pc4, m_pc4);
        chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        chk("pc_misalign", {31'h0, pc_misalign}, {31'h0, m_mis});
        chk("taken_count", {16'h0, taken_count}, m_cnt);
    endtask

    // drive inputs, clock once, then check against the model #1 after the edge
    task automatic step(input bit rn, input bit st, input bit br, input logic [31:0] tgt);
        reset_n = rn; stall = st; is_same = br; branch_target = tgt;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        reset_n = 0; stall = 0; is_same = 0; branch_target = 0;
        m_boot = 1; m_pc = RP; m_inst = 0; m_pc4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;

        // reset and boot
        repeat (3) step(0, 0, 0, 0);
        chk("rst_addr", imem_addr, 32'h100);
        step(1, 1, 1, 32'h0000_0888);   // BOOT ignores stall and is_same
        chk("boot_addr", imem_addr, 32'h100);
        chk("boot_valid", {31'h0, if_id_valid}, 32'h0);
        step(1, 0, 0, 0);
        chk("first_inst", if_id_inst, mem(32'h100));
        chk("first_pc4", if_id_pc4, 32'h104);
        chk("first_valid", {31'h0, if_id_valid}, 32'h1);

        // taken branch: get the branch at 0x200 into ID, then redirect to 0x400
        step(1, 0, 1, 32'h200);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h400);
        chk("br_addr", imem_addr, 32'h400);
        chk("br_count", {16'h0, taken_count}, 32'd2);
`ifdef KIM_BRANCH_DELAY_SLOT_EN
        chk("slot_inst", if_id_inst, mem(32'h204));
        chk("slot_valid", {31'h0, if_id_valid}, 32'h1);
`else
        chk("flush_inst", if_id_inst, 32'h0);
        chk("flush_valid", {31'h0, if_id_valid}, 32'h0);
`endif
        step(1, 0, 0, 0);
        chk("tgt_inst", if_id_inst, mem(32'h400));

        // stall outranks a taken branch
        step(1, 1, 1, 32'h800);
        step(1, 1, 1, 32'h800);
        chk("stall_addr", imem_addr, 32'h404);
        chk("stall_count", {16'h0, taken_count}, 32'd2);
        step(1, 0, 1, 32'h800);
        chk("unstall_addr", imem_addr, 32'h800);
        chk("unstall_count", {16'h0, taken_count}, 32'd3);

        // misaligned target, sticky flag
        step(1, 0, 1, 32'h0000_0402);
        chk("mis_addr", imem_addr, 32'h400);
        repeat (10) step(1, 0, 0, 0);
        chk("mis_sticky", {31'h0, pc_misalign}, 32'h1);

        // PC wrap
        step(1, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);

        // reset concurrent with a taken branch
        step(0, 0, 1, 32'h1000);
        chk("rstbr_addr", imem_addr, RP);
        chk("rstbr_count", {16'h0, taken_count}, 32'd0);
        chk("rstbr_mis", {31'h0, pc_misalign}, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rn = ($urandom_range(0, 99) != 0);
            bit st = ($urandom_range(0, 3) == 0);
            bit br = ($urandom_range(0, 9) < 3);
            logic [31:0] tg = $urandom;
            if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
            step(rn, st, br, tg);
        end

        // counter saturation: 65535 + 2 taken branches
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 65537; i++) begin
            logic [31:0] tg = $urandom & 32'hFFFF_FFFC;
            step(1, 0, 1, tg);
        end
        chk("sat_count", {16'h0, taken_count}, 32'h0000_FFFF);
        step(1, 0, 0, 0);
        chk("sat_hold", {16'h0, taken_count}, 32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/kim_fetch_redirect.md
# kim_fetch_redirect

Instruction-fetch control for the 5-stage pipelined MIPS core. It owns the program counter and the IF/ID pipeline register, and consumes the ID-stage branch decision (`is_same`) and branch target to redirect fetch. It also flushes or keeps the wrong-path instruction, and honours hazard stalls. It sits between instruction memory and the ID stage, at the receiving end of the branch-compare result.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `clk`  in  1: single core clock; all state updates on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `is_same`  in  1: branch taken, from the ID-stage branch compare. Combinational in the current cycle.
- `branch_target`  in  32: ID-stage computed branch target; valid when `is_same`=1.
- `stall`  in  1: hazard-unit stall; holds PC and IF/ID.
- `imem_addr`  out  32: instruction memory address, equal to the PC register. Memory is combinational read.
- `imem_rdata`  in  32: instruction at `imem_addr`, same cycle.
- `if_id_inst`  out  32: registered instruction to ID.
- `if_id_pc4`  out  32: registered PC+4 of that instruction.
- `if_id_valid`  out  1: IF/ID holds a real instruction.
- `pc_misalign`  out  1: sticky flag; a taken target had `[1:0]`≠0.
- `taken_count`  out  16: saturating count of accepted taken branches.

## Operation
- **FSM states:** BOOT, RUN.
  - Reset forces BOOT.
  - BOOT lasts exactly one cycle, then moves unconditionally to RUN. RUN persists until reset.
- **BOOT cycle:**
  - PC holds `RESET_PC`.
  - IF/ID is loaded with a bubble: `if_id_valid`=0, `if_id_inst`=0, `if_id_pc4`=0.
  - `is_same` and `stall` are ignored.
- **RUN priority, evaluated each cycle:**
  1. `stall`=1: PC, IF/ID and `taken_count` hold; `is_same` is ignored. Operands are not ready, so the compare result is not trusted.
  2. `is_same`=1: `pc <= {branch_target[31:2],2'b00}`. `taken_count` increments, saturating at 16'hFFFF. If `branch_target[1:0]`≠0, `pc_misalign` sets.
     - IF/ID is loaded per the Configuration section.
  3. Otherwise: `pc <= pc + 4`, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000). IF/ID loads `imem_rdata`, `pc+4`, valid=1.
- **Flush bubble:** `if_id_inst`=32'h0000_0000 (sll $0 NOP), `if_id_valid`=0. `if_id_pc4` still loads `pc+4`, used for debug only.
- **Sticky flag:** `pc_misalign` clears only on reset.
- **Reset values:**
  - pc = `RESET_PC`
  - `if_id_inst` = 0, `if_id_pc4` = 0, `if_id_valid` = 0
  - `pc_misalign` = 0, `taken_count` = 0
- **Mid-operation reset:** `reset_n`=0 on any edge overrides everything, including a concurrent taken branch or stall. After release, the block passes through BOOT again.

## Timing
- `imem_addr` changes only on clock edges, since it equals the PC register.
- **Sequential fetch:** the instruction at PC p in cycle n appears in `if_id_inst` at n+1.
- **Taken branch:** branch in ID with `is_same`=1 at cycle n.
  - `imem_addr` equals the target at n+1.
  - The target instruction is in IF/ID at n+2.
  - The slot at n+1 is the wrong-path instruction (branch+4), either flushed or kept.
- **Stall:** a stall at cycle n freezes all state at n+1. Fetch resumes the cycle after `stall` falls.
- The first valid instruction (at `RESET_PC`) reaches IF/ID 2 cycles after `reset_n` rises: BOOT cycle, then RUN capture.

## Configuration
- `KIM_BRANCH_DELAY_SLOT_EN`
  - **Defined:** MIPS delay-slot semantics. On a taken branch, IF/ID captures the fetched branch+4 instruction normally (valid=1); no flush.
  - **Undefined:** on a taken branch, IF/ID loads the flush bubble (valid=0).
  - PC redirect, counter and flag behaviour are identical in both builds.

## Test plan
- **Reset/boot:** `RESET_PC`=0x100, hold `reset_n`=0 for 3 cycles, then release → `imem_addr`=0x100 for 2 cycles. `if_id_valid`=0 at release+1. `if_id_inst`=mem[0x100], `if_id_pc4`=0x104, valid=1 at release+2.
- **Taken branch (macro undefined):** branch at 0x200 in ID, `is_same`=1, target=0x400 → next `imem_addr`=0x400, `if_id_valid`=0, `taken_count`=1. The following cycle `if_id_inst`=mem[0x400].
- **Delay slot (macro defined):** same stimulus → `if_id_inst`=mem[0x204] with valid=1, then mem[0x400].
- **Stall priority:** `stall`=1 and `is_same`=1 together for 2 cycles → PC, IF/ID and `taken_count` unchanged. When `stall` drops with `is_same`=1, redirect occurs once and `taken_count`+1.
- **Misaligned target and wrap:**
  - Target 0x0000_0402 → PC=0x400, `pc_misalign`=1, still 1 after 10 further cycles.
  - PC 0xFFFF_FFFC sequential → PC 0x0000_0000.
- **Saturation and reset:**
  - Preload 65,535 taken branches, then 2 more → `taken_count`=0xFFFF.
  - `reset_n`=0 concurrent with `is_same`=1 → PC=`RESET_PC`, count 0.
